shift_unit_pipe: RTL and testbench

- Two-stage registered execution wrapper for the 32-bit shift datapath.
- Sits between the ALU operand-issue logic (upstream) and the writeback mux (downstream).
- Accepts operands and op code on a valid/ready handshake, then computes the shift.
- Returns a registered result with status flags and a sideband tag on a second valid/ready handshake; full throughput, fixed 2-cycle latency.

---
 rtl/shift_unit_pipe_if.sv | 43 ++++
 rtl/shift_unit_pipe.sv | 137 +++++++++++++
 tb/tb_shift_unit_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_unit_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_unit_pipe_if
// Purpose  : Request/response bundle for the two-stage shift unit. Carries
//            the upstream operand handshake and the downstream result
//            handshake.
// Signals  : in_valid/in_ready   - request handshake
//            in_x, in_y, in_op   - operand, shift amount, op code
//            in_tag              - sideband tag, returned with the result
//            out_valid/out_ready - result handshake
//            out_z, out_tag      - result and its tag
//            out_zero, out_ovsh  - result-is-zero, oversized-shift flags
// Modports : master - upstream/downstream side (testbench, issue logic)
//            slave  - the shift unit itself
// Revision : 1.0 - initial release
// ============================================================================
interface shift_unit_pipe_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x;
  logic [31:0]      in_y;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_z;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;
  logic             out_ovsh;

  modport master (
    output in_valid, in_x, in_y, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_z, out_tag, out_zero, out_ovsh
  );

  modport slave (
    input  in_valid, in_x, in_y, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_z, out_tag, out_zero, out_ovsh
  );
endinterface
`default_nettype wire

// File: rtl/shift_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : shift_unit_pipe
// Purpose  : Two-stage registered 32-bit shifter (SRL/SLL/SRA/ROR) with a
//            valid/ready request side and a valid/ready result side. Fixed
//            two-cycle latency, one result per cycle when not stalled.
// Ports    : clk      - clock, rising edge
//            rst      - asynchronous active-high reset
//            bus      - shift_unit_pipe_if.slave (request + result handshakes)
//            op_count - saturating count of completed result transfers
//            busy     - either pipeline stage holds a request
// Revision : 1.0 - initial release
// ============================================================================
module shift_unit_pipe #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  shift_unit_pipe_if.slave bus,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);

  localparam logic [1:0]       c_OP_SRL  = 2'b00;
  localparam logic [1:0]       c_OP_SLL  = 2'b01;
  localparam logic [1:0]       c_OP_SRA  = 2'b10;
  localparam logic [1:0]       c_OP_ROR  = 2'b11;
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  // Stage 1: captured operands
  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_x_q;
  logic [31:0]      s1_y_q;
  logic [1:0]       s1_op_q;
  logic [TAG_W-1:0] s1_tag_q;

  // Stage 2: registered result
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_z_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic             s2_zero_q;
  logic             s2_ovsh_q;

  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic             w_s2_load;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_s1_adv;
  logic             w_xfer;
  logic             w_big;
  logic [4:0]       w_amt;
  logic [31:0]      w_z;
  logic             w_ovsh;

  // Handshake control
  assign w_s2_load  = !s2_valid_q || bus.out_ready;
  assign w_in_ready = !s1_valid_q || w_s2_load;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_s1_adv   = s1_valid_q && w_s2_load;
  assign w_xfer     = s2_valid_q && bus.out_ready;

  // Any of the upper 27 amount bits makes the shift oversized; the amount
  // is treated strictly as unsigned, so bit 31 just means "big".
  assign w_big = |s1_y_q[31:5];
  assign w_amt = s1_y_q[4:0];

  always_comb begin
    w_z    = s1_x_q;
    w_ovsh = w_big && (s1_op_q != c_OP_ROR);
    unique case (s1_op_q)
      c_OP_SRL: w_z = w_big ? 32'd0 : (s1_x_q >> w_amt);
      c_OP_SLL: w_z = w_big ? 32'd0 : (s1_x_q << w_amt);
      c_OP_SRA: w_z = w_big ? {32{s1_x_q[31]}}
                            : 32'($signed(s1_x_q) >>> w_amt);
      // Left-shift by 32 yields 0, so an amount of 0 collapses to X.
      c_OP_ROR: w_z = (s1_x_q >> w_amt) | (s1_x_q << (6'd32 - {1'b0, w_amt}));
      default:  w_z = s1_x_q;
    endcase
  end

  // Next-state for valids and counter
  always_comb begin
    s1_valid_d = w_accept || (s1_valid_q && !w_s1_adv);
    s2_valid_d = w_s2_load ? s1_valid_q : s2_valid_q;
    op_count_d = op_count_q;
    if (w_xfer && (op_count_q != c_CNT_MAX)) begin
      op_count_d = op_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_op_q    <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_z_q     <= '0;
      s2_tag_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_ovsh_q  <= 1'b0;
      op_count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      op_count_q <= op_count_d;
      if (w_accept) begin
        s1_x_q   <= bus.in_x;
        s1_y_q   <= bus.in_y;
        s1_op_q  <= bus.in_op;
        s1_tag_q <= bus.in_tag;
      end
      // S2 data only changes when a request moves in, so a stalled result
      // stays stable on the outputs.
      if (w_s1_adv) begin
        s2_z_q    <= w_z;
        s2_tag_q  <= s1_tag_q;
        s2_zero_q <= (w_z == 32'd0);
        s2_ovsh_q <= w_ovsh;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_z     = s2_z_q;
  assign bus.out_tag   = s2_tag_q;
  assign bus.out_zero  = s2_zero_q;
  assign bus.out_ovsh  = s2_ovsh_q;
  assign op_count      = op_count_q;
  assign busy          = s1_valid_q || s2_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_unit_pipe
// Purpose  : Scoreboard bench for shift_unit_pipe. A driver issues directed
//            and random requests and queues the expected results; a monitor
//            pops and compares on every output transfer. A second instance
//            with a 3-bit counter mirrors the same traffic to exercise
//            counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_unit_pipe;

  localparam int TAG_W = 4;
  localparam int CNT_W = 16;
  localparam int CNT_S = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_unit_pipe_if #(.TAG_W(TAG_W)) bus ();
  shift_unit_pipe_if #(.TAG_W(TAG_W)) bus_s ();

  logic [CNT_W-1:0] op_count;
  logic             busy;
  logic [CNT_S-1:0] op_count_s;
  logic             busy_s;

  shift_unit_pipe #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .op_count(op_count), .busy(busy)
  );

  shift_unit_pipe #(.TAG_W(TAG_W), .CNT_W(CNT_S)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s.slave), .op_count(op_count_s), .busy(busy_s)
  );

  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.in_x      = bus.in_x;
  assign bus_s.in_y      = bus.in_y;
  assign bus_s.in_op     = bus.in_op;
  assign bus_s.in_tag    = bus.in_tag;
  assign bus_s.out_ready = bus.out_ready;

  typedef struct {
    logic [31:0]      z;
    logic [TAG_W-1:0] tag;
    logic             zero;
    logic             ovsh;
    bit               strict;
    int               acc;
  } exp_t;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [1:0]  op;
    logic [31:0] z;
    logic        ov;
  } dv_t;

  exp_t sb[$];
  exp_t cur;
  dv_t  dv[10];

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   n_done = 0;
  int   rmode  = 0;   // 0: always ready, 1: random ready, 2: never ready
  bit   hold_v = 1'b0;
  logic [37:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model straight from the op definitions, using arithmetic.
  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [1:0] op, output logic ovsh);
    logic [31:0] r;
    logic [31:0] nx;
    longint unsigned ux;
    ux   = 64'(x);
    nx   = ~x;
    r    = x;
    ovsh = (y >= 32) && (op != 2'b11);
    case (op)
      2'b00: r = (y >= 32) ? 32'd0 : 32'(ux / (64'd1 << y));
      2'b01: r = (y >= 32) ? 32'd0 : 32'(ux * (64'd1 << y));
      2'b10: begin
        if (x[31] == 1'b0) r = (y >= 32) ? 32'd0 : 32'(ux / (64'd1 << y));
        else               r = (y >= 32) ? 32'hFFFF_FFFF
                                         : ~32'(64'(nx) / (64'd1 << y));
      end
      default: begin
        for (int i = 0; i < int'(y % 32); i++) r = {r[0], r[31:1]};
      end
    endcase
    return r;
  endfunction

  task automatic apply_ready();
    case (rmode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = 1'b0;
    endcase
  endtask

  task automatic set_item(input logic [31:0] x, input logic [31:0] y, input logic [1:0] op,
                          input logic [TAG_W-1:0] tag, input logic [31:0] ez,
                          input logic eov, input bit strict);
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_op    = op;
    bus.in_tag   = tag;
    cur.z        = ez;
    cur.tag      = tag;
    cur.zero     = (ez == 32'd0);
    cur.ovsh     = eov;
    cur.strict   = strict;
    cur.acc      = 0;
  endtask

  // One clock: note acceptance before the edge, then return at edge+1.
  task automatic drive_cycle(output bit acc);
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready && !rst;
    if (acc) begin
      cur.acc = cyc + 1;
      sb.push_back(cur);
    end
    @(posedge clk);
    #1;
    apply_ready();
  endtask

  task automatic wait_accept(input bit strict);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      drive_cycle(acc);
      tries++;
    end
    if (!acc) chk(1'b0, "accept_timeout", 64'(tries), 64'd50);
    if (strict) chk(tries == 1, "in_ready_stream", 64'(tries), 64'd1);
  endtask

  task automatic send_rand(input logic [TAG_W-1:0] tag, input bit strict);
    logic [31:0] x, y, z;
    logic [1:0]  op;
    logic        ov;
    x  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
    op = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0:       y = $urandom_range(0, 31);
      1:       y = $urandom_range(32, 63);
      2:       y = $urandom;
      default: y = 32'h8000_0000 | 32'($urandom_range(0, 31));
    endcase
    z = model(x, y, op, ov);
    set_item(x, y, op, tag, z, ov, strict);
    wait_accept(strict);
  endtask

  task automatic drain();
    int n;
    bus.in_valid = 1'b0;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      apply_ready();
      n++;
    end
    chk(sb.size() == 0 && !bus.out_valid, "drain", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compares every output transfer against the scoreboard.
  initial begin : monitor
    exp_t        e;
    logic [37:0] act, want;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
        n_done = 0;
      end else begin
        act = {bus.out_z, bus.out_tag, bus.out_zero, bus.out_ovsh};
        if (hold_v) chk(bus.out_valid && act == held, "hold", 64'(act), 64'(held));
        if (bus.out_valid && bus.out_ready) begin
          chk(op_count == CNT_W'(n_done), "op_count", 64'(op_count), 64'(n_done));
          chk(op_count_s == ((n_done > 7) ? 3'd7 : 3'(n_done)), "op_count_sat",
              64'(op_count_s), 64'((n_done > 7) ? 7 : n_done));
          if (sb.size() == 0) begin
            chk(1'b0, "unexpected_out", 64'(act), 64'd0);
          end else begin
            e    = sb.pop_front();
            want = {e.z, e.tag, e.zero, e.ovsh};
            chk(act == want, "result", 64'(act), 64'(want));
            if (e.strict) chk(cyc - e.acc == 1, "latency", 64'(cyc - e.acc), 64'd1);
          end
          n_done++;
        end
        hold_v = bus.out_valid && !bus.out_ready;
        held   = act;
      end
    end
  end

  initial begin : driver
    bit acc;
    int nxt;

    dv[0] = '{32'h8000_0000, 32'd31,          2'b00, 32'h0000_0001, 1'b0};
    dv[1] = '{32'h8000_0000, 32'd32,          2'b00, 32'h0000_0000, 1'b1};
    dv[2] = '{32'h8000_0000, 32'h8000_0004,   2'b00, 32'h0000_0000, 1'b1};
    dv[3] = '{32'h8000_0000, 32'd4,           2'b10, 32'hF800_0000, 1'b0};
    dv[4] = '{32'h8000_0000, 32'd40,          2'b10, 32'hFFFF_FFFF, 1'b1};
    dv[5] = '{32'h0000_0001, 32'd33,          2'b11, 32'h8000_0000, 1'b0};
    dv[6] = '{32'h0000_0001, 32'd0,           2'b01, 32'h0000_0001, 1'b0};
    dv[7] = '{32'hDEAD_BEEF, 32'd0,           2'b11, 32'hDEAD_BEEF, 1'b0};
    dv[8] = '{32'h7000_0000, 32'hFFFF_FFFF,   2'b10, 32'h0000_0000, 1'b1};
    dv[9] = '{32'h1234_5678, 32'd8,           2'b01, 32'h3456_7800, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_op     = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk(!bus.out_valid && bus.out_z == 0 && bus.out_tag == 0 && !bus.out_zero
        && !bus.out_ovsh, "reset_outputs", {bus.out_valid, bus.out_z}, 64'd0);
    chk(!busy && bus.in_ready && op_count == 0, "reset_status",
        {busy, bus.in_ready, op_count}, 64'h1_0000);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed boundary vectors under random backpressure
    rmode = 1;
    apply_ready();
    for (int i = 0; i < 10; i++) begin
      set_item(dv[i].x, dv[i].y, dv[i].op, TAG_W'(i), dv[i].z, dv[i].ov, 1'b0);
      wait_accept(1'b0);
    end
    drain();

    // Reset with two requests in flight
    rmode = 0;
    apply_ready();
    send_rand(4'hA, 1'b0);
    send_rand(4'hB, 1'b0);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk(!bus.out_valid && !busy && op_count == 0 && op_count_s == 0 && bus.in_ready,
        "reset_midflight", {bus.out_valid, busy, op_count}, 64'd0);
    sb.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk(!bus.out_valid && !busy, "no_stale", {bus.out_valid, busy}, 64'd0);
    end
    @(posedge clk);
    #1;

    // Streaming: 8 back-to-back, full throughput, fixed latency
    for (int i = 0; i < 8; i++) send_rand(TAG_W'(i), 1'b1);
    drain();
    chk(op_count == 16'd8, "stream_count", 64'(op_count), 64'd8);

    // Backpressure: source stays valid, sink stalls 5 cycles
    rmode = 2;
    apply_ready();
    nxt = 0;
    set_item(32'h0000_00F0, 32'd4, 2'b00, 4'h0, 32'h0000_000F, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(acc);
      if (acc) begin
        nxt++;
        set_item(32'h0000_00F0 + 32'(nxt), 32'd0, 2'b01, TAG_W'(nxt),
                 32'h0000_00F0 + 32'(nxt), 1'b0, 1'b0);
      end
    end
    chk(!bus.in_ready && busy && sb.size() == 2, "bp_buffered",
        {bus.in_ready, 32'(sb.size())}, 64'd2);
    rmode = 0;
    apply_ready();
    wait_accept(1'b0);
    for (int i = 0; i < 3; i++) send_rand(TAG_W'(8 + i), 1'b0);
    drain();

    // Random traffic under random backpressure
    rmode = 1;
    apply_ready();
    for (int i = 0; i < 150; i++) send_rand(TAG_W'($urandom), 1'b0);
    drain();
    chk(op_count == CNT_W'(n_done), "final_count", 64'(op_count), 64'(n_done));
    chk(op_count_s == 3'd7, "final_sat", 64'(op_count_s), 64'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
